// File: rtl/histoframe_mul_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : histoframe_mul_arbiter
//  Purpose  : Round-robin arbiter sharing one pipelined unsigned multiplier
//             between NUM_REQ requesters. It owns the multiplier clock
//             enable, tracks a {valid, tag} slot per multiplier stage and
//             routes each product back to the requester that issued it.
//             Backpressure on the product at the pipeline tail freezes the
//             whole multiplier, so no product can be overwritten.
//
//  Ports    :
//    clk        in   clock
//    reset      in   asynchronous active-high reset
//    req_valid  in   [NUM_REQ]        per-requester operand valid
//    req_ready  out  [NUM_REQ]        operand accepted (one-hot or zero)
//    req_a      in   [NUM_REQ*DIN_W]  packed operand A, req i at [i*DIN_W +: DIN_W]
//    req_b      in   [NUM_REQ*DIN_W]  packed operand B, same packing
//    rsp_valid  out  [NUM_REQ]        product valid (one-hot or zero)
//    rsp_ready  in   [NUM_REQ]        product consumed
//    rsp_data   out  [DOUT_W]         product, broadcast, qualified by rsp_valid
//    mul_ce     out                   multiplier clock enable
//    mul_a      out  [DIN_W]          multiplier operand A
//    mul_b      out  [DIN_W]          multiplier operand B
//    mul_p      in   [DOUT_W]         multiplier product
//    occupancy  out  [ID_W+3]         valid slots in flight (0..LATENCY)
//    busy       out                   occupancy != 0
//
//  Revision : 1.0  initial release
// ============================================================================
module histoframe_mul_arbiter #(
    parameter int NUM_REQ = 2,   // number of requesters (2..8)
    parameter int ID_W    = 1,   // tag width, 2**ID_W >= NUM_REQ
    parameter int LATENCY = 4,   // multiplier latency in enabled cycles
    parameter int DIN_W   = 16,  // operand width
    parameter int DOUT_W  = 26   // truncated product width
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*DIN_W-1:0]   req_a,
    input  logic [NUM_REQ*DIN_W-1:0]   req_b,
    output logic [NUM_REQ-1:0]         rsp_valid,
    input  logic [NUM_REQ-1:0]         rsp_ready,
    output logic [DOUT_W-1:0]          rsp_data,
    output logic                       mul_ce,
    output logic [DIN_W-1:0]           mul_a,
    output logic [DIN_W-1:0]           mul_b,
    input  logic [DOUT_W-1:0]          mul_p,
    output logic [ID_W+2:0]            occupancy,
    output logic                       busy
);

    localparam int OCC_W = ID_W + 3;

    // ------------------------------------------------------------------
    // Slot pipeline state. Slot 0 pairs with the multiplier's first stage,
    // slot LATENCY-1 pairs with mul_p. Only the valid bits are reset; the
    // tags are don't-care whenever their valid bit is clear.
    // ------------------------------------------------------------------
    logic [LATENCY-1:0] r_slot_valid;
    logic [ID_W-1:0]    r_slot_tag [LATENCY];
    logic [ID_W-1:0]    r_rr_ptr;
    logic [OCC_W-1:0]   r_occupancy;

    logic               w_tail_valid;
    logic [ID_W-1:0]    w_tail_tag;
    logic               w_tail_ready;
    logic               w_ce;
    logic               w_retire;

    logic               w_grant_any;
    logic [ID_W-1:0]    w_grant_id;
    logic [ID_W:0]      w_cand;
    logic               w_fire;
    logic [DIN_W-1:0]   w_op_a;
    logic [DIN_W-1:0]   w_op_b;

    assign w_tail_valid = r_slot_valid[LATENCY-1];
    assign w_tail_tag   = r_slot_tag[LATENCY-1];

    // Ready of the consumer that owns the tail product. Tags only ever
    // come from a grant, so they always name an existing requester.
    always_comb begin
        w_tail_ready = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (w_tail_tag == ID_W'(j)) begin
                w_tail_ready = rsp_ready[j];
            end
        end
    end

    // The pipeline advances unless a valid product sits at the tail and
    // its owner is not taking it this cycle.
    assign w_ce     = !w_tail_valid || w_tail_ready;
    assign w_retire = w_tail_valid && w_ce;

    // ------------------------------------------------------------------
    // Round-robin search starting just after the last granted index.
    // The candidate index is computed in ID_W+1 bits so that rr_ptr + k
    // (at most 2*NUM_REQ-1) never overflows before the wrap subtraction.
    // ------------------------------------------------------------------
    always_comb begin
        w_grant_any = 1'b0;
        w_grant_id  = '0;
        w_cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
            if (w_cand >= (ID_W+1)'(NUM_REQ)) begin
                w_cand = w_cand - (ID_W+1)'(NUM_REQ);
            end
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!w_grant_any && req_valid[j] && (w_cand == (ID_W+1)'(j))) begin
                    w_grant_any = 1'b1;
                    w_grant_id  = ID_W'(j);
                end
            end
        end
    end

    // Operand mux for the granted requester.
    always_comb begin
        w_op_a = '0;
        w_op_b = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (w_grant_id == ID_W'(j)) begin
                w_op_a = req_a[j*DIN_W +: DIN_W];
                w_op_b = req_b[j*DIN_W +: DIN_W];
            end
        end
    end

    // An operation issues only when the pipeline moves. Reset is folded in
    // so that nothing appears accepted while the slots are held cleared.
    assign w_fire = w_grant_any && w_ce && !reset;

    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            req_ready[j] = w_fire && (w_grant_id == ID_W'(j));
            rsp_valid[j] = w_tail_valid && (w_tail_tag == ID_W'(j));
        end
    end

    // Operands are driven to zero whenever nothing issues, so an idle or
    // stalled multiplier input is deterministic.
    assign mul_a    = w_fire ? w_op_a : '0;
    assign mul_b    = w_fire ? w_op_b : '0;
    assign mul_ce   = w_ce;
    assign rsp_data = mul_p;

    // ------------------------------------------------------------------
    // Slot valid bits, round-robin pointer and occupancy counter.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_slot_valid <= '0;
            r_rr_ptr     <= ID_W'(NUM_REQ - 1);
            r_occupancy  <= '0;
        end else begin
            if (w_ce) begin
                r_slot_valid[0] <= w_fire;
                for (int i = 1; i < LATENCY; i++) begin
                    r_slot_valid[i] <= r_slot_valid[i-1];
                end
            end
            if (w_fire) begin
                r_rr_ptr <= w_grant_id;
            end
            // Issue and retire on the same edge leave the count unchanged.
            if (w_fire && !w_retire) begin
                r_occupancy <= r_occupancy + OCC_W'(1);
            end else if (!w_fire && w_retire) begin
                r_occupancy <= r_occupancy - OCC_W'(1);
            end
        end
    end

    // Tags travel with the multiplier data and, like it, are not reset.
    always_ff @(posedge clk) begin
        if (w_ce) begin
            r_slot_tag[0] <= w_grant_id;
            for (int i = 1; i < LATENCY; i++) begin
                r_slot_tag[i] <= r_slot_tag[i-1];
            end
        end
    end

    assign occupancy = r_occupancy;
    assign busy      = (r_occupancy != '0);

endmodule
`default_nettype wire

// File: tb/tb_histoframe_mul_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_histoframe_mul_arbiter
//  Purpose  : Self-checking bench for histoframe_mul_arbiter. Two instances
//             (2 and 3 requesters), each with a behavioural 4-stage
//             multiplier and a tag/product scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_histoframe_mul_arbiter;

    localparam int DIN_W  = 16;
    localparam int DOUT_W = 26;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // ---------------- instance with 2 requesters ----------------
    logic [1:0]        req_valid2 = '0, rsp_ready2 = '1;
    logic [1:0]        req_ready2, rsp_valid2;
    logic [31:0]       req_a2 = '0, req_b2 = '0;
    logic [DOUT_W-1:0] rsp_data2, mul_p2;
    logic              mul_ce2, busy2;
    logic [DIN_W-1:0]  mul_a2, mul_b2;
    logic [3:0]        occ2;

    histoframe_mul_arbiter #(.NUM_REQ(2), .ID_W(1), .LATENCY(4),
                             .DIN_W(DIN_W), .DOUT_W(DOUT_W)) u_dut2 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid2), .req_ready(req_ready2),
        .req_a(req_a2), .req_b(req_b2),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2), .rsp_data(rsp_data2),
        .mul_ce(mul_ce2), .mul_a(mul_a2), .mul_b(mul_b2), .mul_p(mul_p2),
        .occupancy(occ2), .busy(busy2)
    );

    // ---------------- instance with 3 requesters ----------------
    logic [2:0]        req_valid3 = '0, rsp_ready3 = '1;
    logic [2:0]        req_ready3, rsp_valid3;
    logic [47:0]       req_a3 = '0, req_b3 = '0;
    logic [DOUT_W-1:0] rsp_data3, mul_p3;
    logic              mul_ce3, busy3;
    logic [DIN_W-1:0]  mul_a3, mul_b3;
    logic [4:0]        occ3;

    histoframe_mul_arbiter #(.NUM_REQ(3), .ID_W(2), .LATENCY(4),
                             .DIN_W(DIN_W), .DOUT_W(DOUT_W)) u_dut3 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid3), .req_ready(req_ready3),
        .req_a(req_a3), .req_b(req_b3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_data(rsp_data3),
        .mul_ce(mul_ce3), .mul_a(mul_a3), .mul_b(mul_b3), .mul_p(mul_p3),
        .occupancy(occ3), .busy(busy3)
    );

    // ---------------- behavioural multipliers (4 enabled stages) ----------
    function automatic logic [DOUT_W-1:0] prod(input logic [15:0] a, input logic [15:0] b);
        logic [31:0] f;
        f = {16'h0, a} * {16'h0, b};
        return f[DOUT_W-1:0];
    endfunction

    logic [DOUT_W-1:0] m2 [4];
    logic [DOUT_W-1:0] m3 [4];
    always_ff @(posedge clk) begin
        if (mul_ce2) begin
            m2[0] <= prod(mul_a2, mul_b2);
            m2[1] <= m2[0]; m2[2] <= m2[1]; m2[3] <= m2[2];
        end
        if (mul_ce3) begin
            m3[0] <= prod(mul_a3, mul_b3);
            m3[1] <= m3[0]; m3[2] <= m3[1]; m3[3] <= m3[2];
        end
    end
    assign mul_p2 = m2[3];
    assign mul_p3 = m3[3];

    // ---------------- scoreboards ----------------
    int                sb2_tag[$], sb3_tag[$];
    logic [DOUT_W-1:0] sb2_dat[$], sb3_dat[$];
    int                glog2[$], glog3[$];

    // Inputs change 1 time unit after posedge, so the negedge sees exactly
    // what the next posedge will act on.
    always @(negedge clk) begin : mon2
        int t;
        logic [DOUT_W-1:0] d;
        if (!reset) begin
            for (int j = 0; j < 2; j++) begin
                if (req_valid2[j] && req_ready2[j]) begin
                    sb2_tag.push_back(j);
                    sb2_dat.push_back(prod(req_a2[j*16 +: 16], req_b2[j*16 +: 16]));
                    glog2.push_back(j);
                end
                if (rsp_valid2[j] && rsp_ready2[j]) begin
                    checks++;
                    if (sb2_tag.size() == 0) begin
                        errors++;
                        $display("FAIL sb2_unexpected: requester %0d got data %0h, required no response", j, rsp_data2);
                    end else begin
                        t = sb2_tag.pop_front();
                        d = sb2_dat.pop_front();
                        if (t !== j || d !== rsp_data2) begin
                            errors++;
                            $display("FAIL sb2_response: got tag %0d data %0h, required tag %0d data %0h", j, rsp_data2, t, d);
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin : mon3
        int t;
        logic [DOUT_W-1:0] d;
        if (!reset) begin
            for (int j = 0; j < 3; j++) begin
                if (req_valid3[j] && req_ready3[j]) begin
                    sb3_tag.push_back(j);
                    sb3_dat.push_back(prod(req_a3[j*16 +: 16], req_b3[j*16 +: 16]));
                    glog3.push_back(j);
                end
                if (rsp_valid3[j] && rsp_ready3[j]) begin
                    checks++;
                    if (sb3_tag.size() == 0) begin
                        errors++;
                        $display("FAIL sb3_unexpected: requester %0d got data %0h, required no response", j, rsp_data3);
                    end else begin
                        t = sb3_tag.pop_front();
                        d = sb3_dat.pop_front();
                        if (t !== j || d !== rsp_data3) begin
                            errors++;
                            $display("FAIL sb3_response: got tag %0d data %0h, required tag %0d data %0h", j, rsp_data3, t, d);
                        end
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic apply_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        sb2_tag.delete(); sb2_dat.delete(); sb3_tag.delete(); sb3_dat.delete();
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((occ2 != 0 || occ3 != 0 || sb2_tag.size() != 0 || sb3_tag.size() != 0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 40) begin
            errors++;
            $display("FAIL drain_timeout: occ2=%0d occ3=%0d pending2=%0d pending3=%0d, required all zero",
                     occ2, occ3, sb2_tag.size(), sb3_tag.size());
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        checks++; if (req_ready2 !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b, required 00", req_ready2); end
        checks++; if (rsp_valid2 !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid: got %b, required 00", rsp_valid2); end
        checks++; if (occ2 !== 4'd0)        begin errors++; $display("FAIL reset_occupancy: got %0d, required 0", occ2); end
        checks++; if (busy2 !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b, required 0", busy2); end
        checks++; if (mul_ce2 !== 1'b1)     begin errors++; $display("FAIL reset_mul_ce: got %b, required 1", mul_ce2); end
        checks++; if (mul_a2 !== 16'd0 || mul_b2 !== 16'd0)
            begin errors++; $display("FAIL reset_mul_ab: got %0h/%0h, required 0/0", mul_a2, mul_b2); end
        checks++; if (occ3 !== 5'd0 || rsp_valid3 !== 3'b000)
            begin errors++; $display("FAIL reset_dut3: got occ %0d rsp_valid %b, required 0/000", occ3, rsp_valid3); end
        // Requests during reset must not be accepted.
        req_valid2 = 2'b11; req_a2 = 32'h0005_0003; req_b2 = 32'h0007_0002;
        #1;
        checks++; if (req_ready2 !== 2'b00) begin errors++; $display("FAIL reset_req_gated: got %b, required 00", req_ready2); end
        req_valid2 = 2'b00;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_single_op();
        rsp_ready2 = 2'b11;
        @(posedge clk); #1;
        req_valid2 = 2'b01; req_a2[15:0] = 16'd300; req_b2[15:0] = 16'd200;
        @(negedge clk);
        checks++; if (req_ready2 !== 2'b01) begin errors++; $display("FAIL single_req_ready: got %b, required 01", req_ready2); end
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            req_valid2 = 2'b00;
            @(negedge clk);
            checks++;
            if (rsp_valid2 !== ((c == 4) ? 2'b01 : 2'b00)) begin
                errors++;
                $display("FAIL single_latency: cycle %0d rsp_valid %b, required %b", c, rsp_valid2, (c == 4) ? 2'b01 : 2'b00);
            end
            if (c == 1) begin
                checks++; if (occ2 !== 4'd1 || busy2 !== 1'b1)
                    begin errors++; $display("FAIL single_occ_busy: got %0d/%b, required 1/1", occ2, busy2); end
            end
            if (c == 4) begin
                checks++; if (rsp_data2 !== 26'd60000)
                    begin errors++; $display("FAIL single_data: got %0d, required 60000", rsp_data2); end
            end
        end
        @(negedge clk);
        checks++; if (occ2 !== 4'd0) begin errors++; $display("FAIL single_occ_end: got %0d, required 0", occ2); end
    endtask

    task automatic test_round_robin();
        apply_reset();
        glog2.delete();
        rsp_ready2 = 2'b11;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            req_valid2 = 2'b11;
            req_a2 = {16'(200 + 10*c), 16'(100 + 10*c)};
            req_b2 = {16'(30 + c), 16'(7 + c)};
            @(negedge clk);
            // Occupancy ramps to 4 and then holds while issue and retire coincide.
            checks++;
            if (occ2 !== 4'((c < 4) ? c : 4)) begin
                errors++;
                $display("FAIL rr_occupancy: cycle %0d got %0d, required %0d", c, occ2, (c < 4) ? c : 4);
            end
        end
        @(posedge clk); #1;
        req_valid2 = 2'b00;
        checks++;
        if (glog2.size() != 6) begin
            errors++; $display("FAIL rr_grant_count: got %0d, required 6", glog2.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (glog2[i] != i % 2) begin
                    errors++; $display("FAIL rr_grant_order: grant %0d got %0d, required %0d", i, glog2[i], i % 2);
                end
            end
        end
        drain();
    endtask

    task automatic test_backpressure();
        int k = 0;
        int guard = 0;
        rsp_ready2 = 2'b01;
        while (k < 4 && guard < 20) begin
            @(posedge clk); #1;
            req_valid2 = 2'b10;
            req_a2[31:16] = 16'(1000 + k);
            req_b2[31:16] = 16'(50 + k);
            @(negedge clk);
            if (req_ready2[1]) k++;
            guard++;
        end
        checks++; if (k != 4) begin errors++; $display("FAIL bp_fill: accepted %0d, required 4", k); end
        @(posedge clk); #1;
        req_valid2 = 2'b01; req_a2[15:0] = 16'd11; req_b2[15:0] = 16'd13;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            checks++;
            if (mul_ce2 !== 1'b0 || req_ready2 !== 2'b00 || rsp_valid2 !== 2'b10 || occ2 !== 4'd4) begin
                errors++;
                $display("FAIL bp_stall: cycle %0d ce %b req_ready %b rsp_valid %b occ %0d, required 0/00/10/4",
                         s, mul_ce2, req_ready2, rsp_valid2, occ2);
            end
            checks++;
            if (rsp_data2 !== prod(16'd1000, 16'd50)) begin
                errors++; $display("FAIL bp_data_hold: cycle %0d got %0h, required %0h", s, rsp_data2, prod(16'd1000, 16'd50));
            end
            if (s < 4) begin @(posedge clk); #1; end
        end
        @(posedge clk); #1;
        req_valid2 = 2'b00;
        rsp_ready2 = 2'b11;
        for (int r = 0; r < 4; r++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid2 !== 2'b10) begin
                errors++; $display("FAIL bp_release: beat %0d rsp_valid %b, required 10", r, rsp_valid2);
            end
        end
        drain();
    endtask

    task automatic test_truncation();
        int n = 0;
        rsp_ready2 = 2'b11;
        @(posedge clk); #1;
        req_valid2 = 2'b10; req_a2[31:16] = 16'hFFFF; req_b2[31:16] = 16'hFFFF;
        @(negedge clk);
        checks++; if (req_ready2 !== 2'b10) begin errors++; $display("FAIL trunc_accept: got %b, required 10", req_ready2); end
        @(posedge clk); #1;
        req_valid2 = 2'b00;
        @(negedge clk);
        while (!rsp_valid2[1] && n < 10) begin @(negedge clk); n++; end
        checks++;
        if (n >= 10) begin
            errors++; $display("FAIL trunc_timeout: rsp_valid %b, required 10", rsp_valid2);
        end else if (rsp_data2 !== 26'h3FE0001) begin
            errors++; $display("FAIL trunc_data: got %0h, required 3fe0001", rsp_data2);
        end
        drain();
    endtask

    task automatic test_reset_midflight();
        rsp_ready2 = 2'b11;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            req_valid2 = 2'b01; req_a2[15:0] = 16'(40 + c); req_b2[15:0] = 16'(3 + c);
        end
        @(posedge clk); #1;
        req_valid2 = 2'b00;
        reset = 1'b1;
        sb2_tag.delete(); sb2_dat.delete(); sb3_tag.delete(); sb3_dat.delete();
        @(negedge clk);
        checks++; if (occ2 !== 4'd0 || busy2 !== 1'b0 || rsp_valid2 !== 2'b00)
            begin errors++; $display("FAIL midreset_clear: occ %0d busy %b rsp_valid %b, required 0/0/00", occ2, busy2, rsp_valid2); end
        @(posedge clk); #1;
        reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid2 !== 2'b00 || occ2 !== 4'd0) begin
                errors++; $display("FAIL midreset_quiet: cycle %0d rsp_valid %b occ %0d, required 00/0", c, rsp_valid2, occ2);
            end
        end
        @(posedge clk); #1;
        req_valid2 = 2'b11;
        @(negedge clk);
        checks++; if (req_ready2 !== 2'b01) begin errors++; $display("FAIL midreset_first_grant: got %b, required 01", req_ready2); end
        @(posedge clk); #1;
        req_valid2 = 2'b00;
        drain();
    endtask

    task automatic test_fairness3();
        rsp_ready3 = 3'b111;
        glog3.delete();
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            req_valid3 = 3'b111;
            req_a3 = {16'(900 + c), 16'(500 + c), 16'(100 + c)};
            req_b3 = {16'(9 + c), 16'(5 + c), 16'(1 + c)};
        end
        @(posedge clk); #1;
        req_valid3 = 3'b000;
        checks++;
        if (glog3.size() != 6) begin
            errors++; $display("FAIL fair3_count: got %0d, required 6", glog3.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (glog3[i] != i % 3) begin
                    errors++; $display("FAIL fair3_order: grant %0d got %0d, required %0d", i, glog3[i], i % 3);
                end
            end
        end
        glog3.delete();
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            req_valid3 = 3'b100;
            req_a3[47:32] = 16'(60000 + c); req_b3[47:32] = 16'(40000 + c);
        end
        @(posedge clk); #1;
        req_valid3 = 3'b000;
        checks++;
        if (glog3.size() != 4) begin
            errors++; $display("FAIL fair3_solo_count: got %0d, required 4", glog3.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (glog3[i] != 2) begin
                    errors++; $display("FAIL fair3_solo: grant %0d got %0d, required 2", i, glog3[i]);
                end
            end
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_round_robin();
        test_backpressure();
        test_truncation();
        test_reset_midflight();
        test_fairness3();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
